// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the next-PC prediction unit.
//   - resolve-kind encodings presented by the ID stage
//   - 2-bit saturating counter states used by the BTB
//   - default reset and exception-entry addresses
package npc_pkg;

   localparam logic [1:0] KIND_COND = 2'b00;   // conditional branch
   localparam logic [1:0] KIND_JMP  = 2'b01;   // direct jump (J/JAL)
   localparam logic [1:0] KIND_IND  = 2'b10;   // indirect (JR/BGEZALR)

   localparam logic [1:0] CTR_SNT = 2'b00;     // strongly not-taken
   localparam logic [1:0] CTR_WNT = 2'b01;     // weakly not-taken
   localparam logic [1:0] CTR_WT  = 2'b10;     // weakly taken
   localparam logic [1:0] CTR_ST  = 2'b11;     // strongly taken

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/npc_btb.sv
// npc_btb: direct-mapped branch target buffer with 2-bit saturating counters.
//   Lookup is combinational on lookup_pc; updates land on the rising edge, so
//   a same-index read in the update cycle still sees the old contents.
// Ports:
//   clk, rst_n              clock, async active-low reset (valid=0, ctr=WNT)
//   lookup_pc               IF fetch address
//   pred_taken, pred_target prediction for lookup_pc
//   upd_en                  resolved control transfer to train on
//   upd_pc, upd_taken,
//   upd_target              resolved address, outcome and target
module npc_btb
   import npc_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int BTB_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic [BTB_DEPTH-1:0] valid_q;
   logic [1:0]           ctr_q    [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
   logic [ADDR_W-1:0]    target_q [BTB_DEPTH];

   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic             rd_hit;
   logic             wr_hit;

   // Instructions are word aligned; the byte offset never selects anything.
   logic [3:0] unused_pc_lsb;
   assign unused_pc_lsb = {lookup_pc[1:0], upd_pc[1:0]};

   assign rd_idx = lookup_pc[IDX_W+1:2];
   assign rd_tag = lookup_pc[ADDR_W-1:IDX_W+2];
   assign wr_idx = upd_pc[IDX_W+1:2];
   assign wr_tag = upd_pc[ADDR_W-1:IDX_W+2];

   assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
   assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
   assign pred_target = target_q[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            ctr_q[i]    <= CTR_WNT;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (upd_en) begin
         if (wr_hit) begin
            if (upd_taken) begin
               if (ctr_q[wr_idx] != CTR_ST) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
               target_q[wr_idx] <= upd_target;
            end else if (ctr_q[wr_idx] != CTR_SNT) begin
               ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Not-taken misses are not allocated: they would predict
            // fall-through anyway and only evict useful entries.
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd_target;
            ctr_q[wr_idx]    <= CTR_WT;
         end
      end
   end

endmodule

// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch PC register, IF-stage branch prediction and
// ID-stage resolution with redirect on misprediction, exception and ERET.
// Build option:
//   NPC_BTB_PREDICT_EN  defined   -> BTB-based dynamic prediction
//                       undefined -> static not-taken, no BTB storage
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall_i               hold PC and ID prediction record
//   pc_o, pc_plus4_o      fetch PC and fetch PC + 4
//   pred_taken_o          prediction for pc_o
//   resolve_*_i           control transfer resolved in ID this cycle
//   flush_o               kill the IF instruction (same cycle as cause)
//   exc_i, eret_i, epc_i  exception entry / return and return address
module npc_predict_unit
   import npc_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
   parameter int                BTB_DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic              pred_taken_o,
   input  logic              resolve_valid_i,
   input  logic [ADDR_W-1:0] resolve_pc_i,
   input  logic [1:0]        resolve_kind_i,
   input  logic              resolve_taken_i,
   input  logic [ADDR_W-1:0] resolve_target_i,
   output logic              flush_o,
   input  logic              exc_i,
   input  logic              eret_i,
   input  logic [ADDR_W-1:0] epc_i
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] correct_pc;
   logic [ADDR_W-1:0] pred_target;
   logic [ADDR_W-1:0] pred_target_d;
   logic              pred_taken;
   logic              pred_taken_d;
   logic              mispredict;
   logic              redirect;

   // The outcome and target fully determine the redirect; kind is informational.
   logic [1:0] unused_kind;
   assign unused_kind = resolve_kind_i;

`ifdef NPC_BTB_PREDICT_EN
   npc_btb #(
      .ADDR_W    (ADDR_W),
      .BTB_DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .lookup_pc   (pc_q),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_en      (resolve_valid_i & ~exc_i),
      .upd_pc      (resolve_pc_i),
      .upd_taken   (resolve_taken_i),
      .upd_target  (resolve_target_i)
   );
`else
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
`endif

   assign pc_plus4   = pc_q + ADDR_W'(4);
   assign correct_pc = resolve_taken_i ? resolve_target_i : resolve_pc_i + ADDR_W'(4);

   assign mispredict = resolve_valid_i &
                       ((resolve_taken_i != pred_taken_d) |
                        (resolve_taken_i & (resolve_target_i != pred_target_d)));
   assign redirect   = exc_i | eret_i | mispredict;

   always_comb begin
      pc_next = pc_plus4;
      if (exc_i)           pc_next = EXC_VECTOR;
      else if (eret_i)     pc_next = epc_i;
      else if (mispredict) pc_next = correct_pc;
      else if (stall_i)    pc_next = pc_q;
      else if (pred_taken) pc_next = pred_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         pred_taken_d  <= 1'b0;
         pred_target_d <= '0;
      end else begin
         pc_q <= pc_next;
         // The instruction killed by a redirect never reaches ID, so its
         // prediction must not be compared against the next resolve.
         if (redirect) begin
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
         end else if (!stall_i) begin
            pred_taken_d  <= pred_taken;
            pred_target_d <= pred_target;
         end
      end
   end

   assign pc_o         = pc_q;
   assign pc_plus4_o   = pc_plus4;
   assign pred_taken_o = pred_taken;
   assign flush_o      = redirect;

endmodule

// File: tb/tb_npc_predict_unit.sv
module tb_npc_predict_unit;

   localparam int DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;
`ifdef NPC_BTB_PREDICT_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   logic        clk, rst_n, stall_i;
   logic [31:0] pc_o, pc_plus4_o;
   logic        pred_taken_o;
   logic        resolve_valid_i;
   logic [31:0] resolve_pc_i;
   logic [1:0]  resolve_kind_i;
   logic        resolve_taken_i;
   logic [31:0] resolve_target_i;
   logic        flush_o, exc_i, eret_i;
   logic [31:0] epc_i;

   int total = 0;
   int bad   = 0;

   npc_predict_unit #(.BTB_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .pred_taken_o(pred_taken_o),
      .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
      .resolve_kind_i(resolve_kind_i), .resolve_taken_i(resolve_taken_i),
      .resolve_target_i(resolve_target_i), .flush_o(flush_o),
      .exc_i(exc_i), .eret_i(eret_i), .epc_i(epc_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          st, rv, rt, exc, eret;
      logic [31:0] rpc, rtgt, epc;
   } stim_t;

   function automatic stim_t mk(bit st, bit rv, logic [31:0] rpc, bit rt,
                                logic [31:0] rtgt, bit exc, bit eret, logic [31:0] epc);
      stim_t s;
      s.st = st; s.rv = rv; s.rpc = rpc; s.rt = rt; s.rtgt = rtgt;
      s.exc = exc; s.eret = eret; s.epc = epc;
      return s;
   endfunction

   task automatic drive(stim_t s);
      stall_i = s.st; resolve_valid_i = s.rv; resolve_pc_i = s.rpc;
      resolve_taken_i = s.rt; resolve_target_i = s.rtgt;
      resolve_kind_i = s.rt ? 2'b01 : 2'b00;
      exc_i = s.exc; eret_i = s.eret; epc_i = s.epc;
   endtask

   // Reference model: a table of remembered branches keyed by word address,
   // each with a confidence level 0..3 (>=2 means predict taken).
   logic [31:0] m_pc, m_td;
   bit          m_pd;
   bit          mv    [DEPTH];
   logic [31:0] mword [DEPTH];
   logic [31:0] mtgt  [DEPTH];
   int          mconf [DEPTH];
   bit          e_pred, e_flush;
   logic [31:0] e_tgt, e_next;

   task automatic model_reset();
      m_pc = RST_PC; m_pd = 1'b0; m_td = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mv[i] = 1'b0; mconf[i] = 1; mword[i] = '0; mtgt[i] = '0;
      end
   endtask

   task automatic model_eval();
      int i;
      bit mis;
      i = int'((m_pc >> 2) % DEPTH);
      e_pred = BTB_ON && mv[i] && (mword[i] == (m_pc >> 2)) && (mconf[i] >= 2);
      e_tgt  = e_pred ? mtgt[i] : 32'h0;
      mis = resolve_valid_i &&
            ((resolve_taken_i != m_pd) || (resolve_taken_i && resolve_target_i != m_td));
      e_flush = exc_i || eret_i || mis;
      if (exc_i)        e_next = EXC_PC;
      else if (eret_i)  e_next = epc_i;
      else if (mis)     e_next = resolve_taken_i ? resolve_target_i : resolve_pc_i + 32'd4;
      else if (stall_i) e_next = m_pc;
      else if (e_pred)  e_next = e_tgt;
      else              e_next = m_pc + 32'd4;
   endtask

   task automatic model_commit();
      int j;
      if (e_flush) begin
         m_pd = 1'b0; m_td = '0;
      end else if (!stall_i) begin
         m_pd = e_pred; m_td = e_tgt;
      end
      if (BTB_ON && resolve_valid_i && !exc_i) begin
         j = int'((resolve_pc_i >> 2) % DEPTH);
         if (mv[j] && mword[j] == (resolve_pc_i >> 2)) begin
            if (resolve_taken_i) begin
               mconf[j] = (mconf[j] == 3) ? 3 : mconf[j] + 1;
               mtgt[j]  = resolve_target_i;
            end else begin
               mconf[j] = (mconf[j] == 0) ? 0 : mconf[j] - 1;
            end
         end else if (resolve_taken_i) begin
            mv[j] = 1'b1; mword[j] = resolve_pc_i >> 2;
            mtgt[j] = resolve_target_i; mconf[j] = 2;
         end
      end
      m_pc = e_next;
   endtask

   stim_t idle;

   task automatic test_reset();
      #12;
      total++;
      if (pc_o !== RST_PC || pred_taken_o !== 1'b0 || flush_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold pc=%h pred=%b flush=%b exp pc=%h pred=0 flush=0",
                  pc_o, pred_taken_o, flush_o, RST_PC);
      end
      #5 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(idle); model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== RST_PC + 32'(4 * k) || pc_o !== m_pc) begin
            bad++; $display("FAIL reset_seq[%0d] pc got %h exp %h", k, pc_o, RST_PC + 32'(4 * k));
         end
         total++;
         if (pc_plus4_o !== m_pc + 32'd4) begin
            bad++; $display("FAIL reset_pc4[%0d] got %h exp %h", k, pc_plus4_o, m_pc + 32'd4);
         end
         total++;
         if (pred_taken_o !== 1'b0 || flush_o !== 1'b0) begin
            bad++; $display("FAIL reset_pred[%0d] pred=%b flush=%b exp 0/0", k, pred_taken_o, flush_o);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_learn();
      stim_t t[$];
      t.push_back(mk(0, 1, 32'h3008, 1, 32'h3020, 0, 0, 0));
      t.push_back(idle);
      for (int r = 0; r < 4; r++) begin
         t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3008));
         t.push_back(idle);
         t.push_back(mk(0, 1, 32'h3008, (r == 0), 32'h3020, 0, 0, 0));
      end
      foreach (t[k]) begin
         drive(t[k]); model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL learn_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (pred_taken_o !== e_pred) begin
            bad++; $display("FAIL learn_pred[%0d] got %b exp %b", k, pred_taken_o, e_pred);
         end
         total++;
         if (flush_o !== e_flush) begin
            bad++; $display("FAIL learn_flush[%0d] got %b exp %b", k, flush_o, e_flush);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_stall();
      stim_t t[$];
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3010));
      t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      t.push_back(mk(1, 1, 32'h3050, 1, 32'h3080, 0, 0, 0));
      t.push_back(idle);
      foreach (t[k]) begin
         drive(t[k]); model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL stall_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (flush_o !== e_flush) begin
            bad++; $display("FAIL stall_flush[%0d] got %b exp %b", k, flush_o, e_flush);
         end
         total++;
         if (pred_taken_o !== e_pred) begin
            bad++; $display("FAIL stall_pred[%0d] got %b exp %b", k, pred_taken_o, e_pred);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_priority();
      stim_t t[$];
      t.push_back(mk(0, 1, 32'h3060, 1, 32'h3070, 1, 1, 32'h3040));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3040));
      t.push_back(idle);
      t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC));
      t.push_back(idle);
      t.push_back(idle);
      foreach (t[k]) begin
         drive(t[k]); model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL prio_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (pc_plus4_o !== m_pc + 32'd4) begin
            bad++; $display("FAIL prio_pc4[%0d] got %h exp %h", k, pc_plus4_o, m_pc + 32'd4);
         end
         total++;
         if (flush_o !== e_flush) begin
            bad++; $display("FAIL prio_flush[%0d] got %b exp %b", k, flush_o, e_flush);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_alias();
      stim_t t[$];
      t.push_back(mk(0, 1, 32'h3000, 1, 32'h3100, 0, 0, 0));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3000));
      t.push_back(idle);
      t.push_back(mk(0, 1, 32'h3000, 1, 32'h3100, 0, 0, 0));
      t.push_back(mk(0, 1, 32'h3010, 1, 32'h3200, 0, 0, 0));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3000));
      t.push_back(idle);
      t.push_back(idle);
      foreach (t[k]) begin
         drive(t[k]); model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL alias_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (pred_taken_o !== e_pred) begin
            bad++; $display("FAIL alias_pred[%0d] got %b exp %b", k, pred_taken_o, e_pred);
         end
         total++;
         if (flush_o !== e_flush) begin
            bad++; $display("FAIL alias_flush[%0d] got %b exp %b", k, flush_o, e_flush);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int k = 0; k < 400; k++) begin
         s.st   = ($urandom_range(0, 3) == 0);
         s.rv   = ($urandom_range(0, 9) < 4);
         s.rt   = $urandom_range(0, 1);
         s.rpc  = 32'h3000 + 32'(4 * $urandom_range(0, 15));
         s.rtgt = 32'h3000 + 32'(4 * $urandom_range(0, 15));
         s.exc  = ($urandom_range(0, 31) == 0);
         s.eret = ($urandom_range(0, 31) == 0);
         s.epc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                               : 32'h3000 + 32'(4 * $urandom_range(0, 15));
         drive(s);
         if (s.rt) resolve_kind_i = 2'($urandom_range(1, 2));
         model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL rand_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (pred_taken_o !== e_pred) begin
            bad++; $display("FAIL rand_pred[%0d] got %b exp %b", k, pred_taken_o, e_pred);
         end
         total++;
         if (flush_o !== e_flush) begin
            bad++; $display("FAIL rand_flush[%0d] got %b exp %b", k, flush_o, e_flush);
         end
         total++;
         if (pc_plus4_o !== m_pc + 32'd4) begin
            bad++; $display("FAIL rand_pc4[%0d] got %h exp %h", k, pc_plus4_o, m_pc + 32'd4);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   task automatic test_reset_mid();
      drive(mk(0, 1, 32'h3024, 1, 32'h3090, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (pc_o !== RST_PC || pred_taken_o !== 1'b0) begin
         bad++; $display("FAIL midreset_async pc=%h pred=%b exp %h/0", pc_o, pred_taken_o, RST_PC);
      end
      @(posedge clk); #1;
      total++;
      if (pc_o !== RST_PC) begin
         bad++; $display("FAIL midreset_hold pc got %h exp %h", pc_o, RST_PC);
      end
      drive(idle);
      #2 rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 5; k++) begin
         if (k == 3) drive(mk(0, 0, 0, 0, 0, 0, 1, 32'h3008)); else drive(idle);
         model_eval();
         @(negedge clk);
         total++;
         if (pc_o !== m_pc) begin
            bad++; $display("FAIL midreset_pc[%0d] got %h exp %h", k, pc_o, m_pc);
         end
         total++;
         if (pred_taken_o !== e_pred || flush_o !== e_flush) begin
            bad++; $display("FAIL midreset_pf[%0d] pred=%b flush=%b exp %b/%b",
                            k, pred_taken_o, flush_o, e_pred, e_flush);
         end
         @(posedge clk); #1; model_commit();
      end
   endtask

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      drive(idle);
      model_reset();
      test_reset();
      test_learn();
      test_stall();
      test_priority();
      test_alias();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
